acc_sfp_bank: RTL
=================

ACC_SFP_BANK -- requirements
Module: acc_sfp_bank

Interface
REQ-001 SHALL have parameter COL, default 8, number of psum channels.
REQ-002 SHALL have parameter PSUM_BW, default 16, signed psum width per channel.
REQ-003 SHALL have parameter DEPTH, default 16, accumulation entries per channel; AW = clog2(DEPTH).
REQ-004 SHALL have ports: clk  in  1  clock; reset  in  1  asynchronous active-high reset.
REQ-005 SHALL have port in_valid  in  1  input beat valid.
REQ-006 SHALL have port in_ready  out  1  input beat accepted when in_valid & in_ready.
REQ-007 SHALL have port in_data  in  COL*PSUM_BW  psum vector, channel i at bits [PSUM_BW*(i+1)-1:PSUM_BW*i].
REQ-008 SHALL have port in_addr  in  AW  target entry.
REQ-009 SHALL have port in_first  in  1  beat overwrites the entry instead of adding.
REQ-010 SHALL have port relu_en  in  1  apply max(x, thres) on output.
REQ-011 SHALL have port thres  in  PSUM_BW  signed ReLU floor.
REQ-012 SHALL have port drain_start  in  1  pulse: stream out all entries.
REQ-013 SHALL have port out_valid  out  1; out_ready  in  1; out_data  out  COL*PSUM_BW; out_addr  out  AW.
REQ-014 SHALL have port done  out  1  one-cycle pulse at end of drain; ovf  out  COL  sticky per-channel saturation flag.

Function
REQ-015 SHALL implement FSM states IDLE, DRAIN, DONE; IDLE->DRAIN on drain_start, DRAIN->DONE after entry DEPTH-1 is accepted by the consumer, DONE->IDLE unconditionally next cycle.
REQ-016 SHALL assert in_ready only in IDLE.
REQ-017 SHALL, on an accepted beat, write entry[in_addr] = in_first ? in_data : sat(entry[in_addr] + in_data) per channel, visible to a beat on the next cycle.
REQ-018 SHALL saturate each channel sum to [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1] and set the matching ovf bit when clamping occurs.
REQ-019 SHALL, for back-to-back beats to the same address, forward the just-written value so each beat accumulates correctly.
REQ-020 SHALL, in DRAIN, present entries in ascending address 0..DEPTH-1, one per cycle when out_ready stays high, out_valid registered one cycle after entering DRAIN.
REQ-021 SHALL hold out_data/out_addr/out_valid stable while out_valid & !out_ready.
REQ-022 SHALL apply relu_en/thres per channel to drained data only; stored entries unaffected by the function.
REQ-023 SHALL clear each entry to zero when it is accepted during drain.
REQ-024 SHALL ignore drain_start outside IDLE; a beat accepted in the same cycle as drain_start SHALL be written before entry 0 is read.
REQ-025 SHALL assert done for exactly one cycle in DONE; out_valid low in DONE and IDLE.
REQ-026 SHALL clear ovf only on reset.

Reset
REQ-027 SHALL, on reset, go to IDLE asynchronously with out_valid=0, done=0, ovf=0, out_data=0, out_addr=0, in_ready=1 after release.
REQ-028 SHALL zero all DEPTH entries on reset, including reset asserted mid-drain (drain aborted, no done).

Structure
REQ-029 SHALL place FSM state encoding and the saturation-limit constants in the shared project package.
REQ-030 SHALL use one sub-module, sfp_lane, instantiated COL times, holding the saturating add, ovf detect and ReLU of one channel; storage and FSM stay in acc_sfp_bank.

Verification
REQ-031 Bench SHALL check: beats addr 3 with in_first=1 data 5, then 7, then -2 (all channels) -> drain shows entry 3 = 10, others 0.
REQ-032 Bench SHALL check: two beats of 30000 to addr 0, PSUM_BW=16 -> entry 0 drains as 32767, ovf all ones.
REQ-033 Bench SHALL check: relu_en=1, thres=0, entry -9 -> out 0; thres=4, entry 2 -> out 4; relu_en=0, entry -9 -> out -9.
REQ-034 Bench SHALL check: drain with out_ready toggling 1,0,0,1 -> addresses 0..DEPTH-1 each exactly once, data stable while stalled, done one cycle after last handshake, in_ready low throughout drain.
REQ-035 Bench SHALL check: second drain immediately after done -> all entries 0 (cleared).
REQ-036 Bench SHALL check: reset asserted at drain address 5 -> out_valid drops asynchronously, no done, subsequent drain returns all zeros.

Source files
------------

// File: rtl/acc_sfp_bank_pkg.sv
// rtl/acc_sfp_bank_pkg.sv - shared FSM encoding and saturation limits for the accumulator bank
package acc_sfp_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int SAT_CALC_W = 64;

  function automatic logic signed [SAT_CALC_W-1:0] sat_hi(input int bw);
    return (64'sd1 <<< (bw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [SAT_CALC_W-1:0] sat_lo(input int bw);
    return -(64'sd1 <<< (bw - 1));
  endfunction

endpackage

// File: rtl/acc_sfp_bank_sfp_lane.sv
// rtl/acc_sfp_bank_sfp_lane.sv - one psum channel: saturating add with overflow flag, ReLU floor on drain
module sfp_lane #(
  parameter int PSUM_BW = 16
) (
  input  logic               first,
  input  logic [PSUM_BW-1:0] acc,
  input  logic [PSUM_BW-1:0] din,
  input  logic               relu_en,
  input  logic [PSUM_BW-1:0] thres,
  input  logic [PSUM_BW-1:0] raw,
  output logic [PSUM_BW-1:0] wr_val,
  output logic               ovf_hit,
  output logic [PSUM_BW-1:0] drain_val
);
  import acc_sfp_bank_pkg::*;

  localparam logic signed [SAT_CALC_W-1:0] HI64 = sat_hi(PSUM_BW);
  localparam logic signed [SAT_CALC_W-1:0] LO64 = sat_lo(PSUM_BW);
  localparam logic [PSUM_BW-1:0] HI = HI64[PSUM_BW-1:0];
  localparam logic [PSUM_BW-1:0] LO = LO64[PSUM_BW-1:0];

  logic [PSUM_BW:0] sum;

  always_comb begin
    sum     = {acc[PSUM_BW-1], acc} + {din[PSUM_BW-1], din};
    wr_val  = sum[PSUM_BW-1:0];
    ovf_hit = 1'b0;
    if (first) begin
      wr_val = din;
    end else if (sum[PSUM_BW] != sum[PSUM_BW-1]) begin
      // guard bit disagreeing with the sign bit means the true sum left the range
      ovf_hit = 1'b1;
      wr_val  = sum[PSUM_BW] ? LO : HI;
    end
    drain_val = raw;
    if (relu_en && ($signed(raw) < $signed(thres))) begin
      drain_val = thres;
    end
  end

endmodule

// File: rtl/acc_sfp_bank.sv
// rtl/acc_sfp_bank.sv - multi-channel psum accumulation bank with saturating add and ReLU drain
module acc_sfp_bank #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int DEPTH   = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int DW     = COL * PSUM_BW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [AW-1:0] in_addr,
  input  logic          in_first,
  input  logic          relu_en,
  input  logic [PSUM_BW-1:0] thres,
  input  logic          drain_start,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          done,
  output logic [COL-1:0] ovf
);
  import acc_sfp_bank_pkg::*;

  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

  state_t        state, state_next;
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   cnt;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] wr_vec, drain_vec;
  logic [COL-1:0] ovf_hit;
  logic          beat, accept, last_acc, load;

  assign in_ready = (state == ST_IDLE);
  assign beat     = in_valid & in_ready;
  assign accept   = out_valid & out_ready;
  assign last_acc = accept && (out_addr == LAST_A);
  assign rd_addr  = cnt[AW-1:0];
  assign load     = (state == ST_DRAIN) && (cnt < DEPTH_C) && (!out_valid || out_ready);

  for (genvar i = 0; i < COL; i++) begin : g_lane
    sfp_lane #(.PSUM_BW(PSUM_BW)) u_lane (
      .first     (in_first),
      .acc       (mem[in_addr][PSUM_BW*i +: PSUM_BW]),
      .din       (in_data[PSUM_BW*i +: PSUM_BW]),
      .relu_en   (relu_en),
      .thres     (thres),
      .raw       (mem[rd_addr][PSUM_BW*i +: PSUM_BW]),
      .wr_val    (wr_vec[PSUM_BW*i +: PSUM_BW]),
      .ovf_hit   (ovf_hit[i]),
      .drain_val (drain_vec[PSUM_BW*i +: PSUM_BW])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      ST_IDLE:  if (drain_start) state_next = ST_DRAIN;
      ST_DRAIN: if (last_acc) state_next = ST_DONE;
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // Entries are flops read combinationally, so a beat written this edge is
  // already seen by the next beat or by the first drain read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      ovf       <= '0;
    end else begin
      if (beat) begin
        mem[in_addr] <= wr_vec;
        ovf          <= ovf | ovf_hit;
      end
      if (state == ST_IDLE) cnt <= '0;
      if (accept) begin
        mem[out_addr] <= '0;
        out_valid     <= 1'b0;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= drain_vec;
        out_addr  <= rd_addr;
        cnt       <= cnt + 1'b1;
      end
    end
  end

endmodule
